// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_t : sequencer states (RUN, MEM_WAIT)
//   REG_ZERO   : architectural r0 (never a real dependency)
//   JUMP_NONE  : jump code meaning "no redirect"
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam logic [1:0] JUMP_NONE = 2'b00;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags a hazard when the instruction in EXE is a load whose destination
// is a source register actually read by the instruction in ID.
// Ports:
//   id_rs_addr, id_rt_addr  : source register fields of the ID instruction
//   id_uses_rs, id_uses_rt  : which of those fields are really read
//   exe_mem_to_reg          : EXE instruction is a load
//   exe_rd_addr             : destination register of the EXE instruction
//   hazard                  : ID must wait one cycle for the load data
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       exe_mem_to_reg,
  input  logic [4:0] exe_rd_addr,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = id_uses_rs && (id_rs_addr == exe_rd_addr);
  assign rt_match = id_uses_rt && (id_rt_addr == exe_rd_addr);

  // A load into r0 produces nothing to wait for.
  assign hazard = exe_mem_to_reg && (exe_rd_addr != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage MIPS pipeline.
// Decides every cycle which pipeline registers hold and which take a bubble:
// cache misses freeze everything, EXE-resolved jumps flush IF/ID and ID/EXE,
// load-use hazards insert a one-cycle bubble into ID/EXE.
// Ports:
//   clk, rst_b            : clock; rst_b is an asynchronous active-HIGH reset
//   id_*                  : source-register info of the ID instruction
//   exe_mem_to_reg,
//   exe_rd_addr, exe_jump : EXE instruction load flag, destination, jump code
//   mem_cache_en,
//   mem_ready             : MEM-stage cache handshake
//   freeze_*              : hold the corresponding pipeline register
//   flush_if_id,
//   flush_id_exe          : load a NOP into that register at the next edge
//   mem_err               : sticky cache-wait timeout flag
//   stall_cnt             : count of cycles with freeze_pc asserted (wraps)
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [4:0]       id_rs_addr,
  input  logic [4:0]       id_rt_addr,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_mem_to_reg,
  input  logic [4:0]       exe_rd_addr,
  input  logic [1:0]       exe_jump,
  input  logic             mem_cache_en,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             freeze_id_exe,
  output logic             freeze_exe_mem,
  output logic             freeze_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_exe,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WAIT_W      = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX    = '1;
  localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_t         state;
  hz_state_t         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_inc;
  logic              hazard;
  logic              miss;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
  endfunction

  load_use_detect u_load_use_detect (
    .id_rs_addr     (id_rs_addr),
    .id_rt_addr     (id_rt_addr),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .exe_mem_to_reg (exe_mem_to_reg),
    .exe_rd_addr    (exe_rd_addr),
    .hazard         (hazard)
  );

  // Miss condition: in RUN only a real cache access can miss; in MEM_WAIT
  // the access is already outstanding, so mem_cache_en no longer matters.
  always_comb begin
    miss = 1'b0;
    if (!rst_b) begin
      if (state == MEM_WAIT) miss = !mem_ready;
      else                   miss = mem_cache_en && !mem_ready;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) state <= RUN;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_cache_en && !mem_ready) state_nxt = MEM_WAIT;
      MEM_WAIT: if (mem_ready)                  state_nxt = RUN;
      default:                                  state_nxt = RUN;
    endcase
  end

  // Output logic. In the mem_ready cycle of MEM_WAIT, miss is already low,
  // so jump/load-use are evaluated with the RUN priorities against the
  // EXE/ID contents that were held during the wait.
  always_comb begin
    freeze_pc      = 1'b0;
    freeze_if_id   = 1'b0;
    freeze_id_exe  = 1'b0;
    freeze_exe_mem = 1'b0;
    freeze_mem_wb  = 1'b0;
    flush_if_id    = 1'b0;
    flush_id_exe   = 1'b0;
    if (!rst_b) begin
      if (miss) begin
        freeze_pc      = 1'b1;
        freeze_if_id   = 1'b1;
        freeze_id_exe  = 1'b1;
        freeze_exe_mem = 1'b1;
        freeze_mem_wb  = 1'b1;
      end else if (exe_jump != JUMP_NONE) begin
        // The ID instruction is discarded, so its load-use hazard is moot.
        flush_if_id  = 1'b1;
        flush_id_exe = 1'b1;
      end else if (hazard) begin
        freeze_pc    = 1'b1;
        freeze_if_id = 1'b1;
        flush_id_exe = 1'b1;
      end
    end
  end

  assign wait_inc = sat_inc(wait_cnt);

  // Wait timer and sticky timeout flag
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else if (state == RUN) begin
      if (state_nxt == MEM_WAIT) wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_inc;
      if (wait_inc >= TIMEOUT_LIM) mem_err <= 1'b1;
    end
  end

  // Stall statistics
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b)          stall_cnt <= '0;
    else if (freeze_pc) stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It decides each cycle whether the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers freeze or take a bubble, based on:
- load-use hazards between ID and EXE;
- cache-miss waits in MEM;
- jumps resolved in EXE.

It sits beside the datapath and drives the `freeze` inputs of every pipeline register plus their bubble/flush controls.

## Interface
Parameters:
- `MEM_TIMEOUT`, 64: cycles in a cache wait before `mem_err` is raised.
- `CNT_W`, 32: width of the stall counter.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pipeline clock, rising edge.
- `rst_b`  in  1  asynchronous, active-high reset. Asserted (1) means reset, despite the suffix.
- `id_rs_addr`  in  5  rs field of the instruction in ID.
- `id_rt_addr`  in  5  rt field of the instruction in ID.
- `id_uses_rs`  in  1  ID instruction reads rs.
- `id_uses_rt`  in  1  ID instruction reads rt.
- `exe_mem_to_reg`  in  1  instruction in EXE is a load.
- `exe_rd_addr`  in  5  destination register of the EXE instruction.
- `exe_jump`  in  2  jump code of the EXE instruction; nonzero means redirect taken.
- `mem_cache_en`  in  1  MEM stage is accessing the cache this cycle.
- `mem_ready`  in  1  cache has the data or write complete this cycle.
- `freeze_pc`  out  1  hold the PC.
- `freeze_if_id`  out  1  hold IF/ID.
- `freeze_id_exe`  out  1  hold ID/EXE.
- `freeze_exe_mem`  out  1  hold EXE/MEM.
- `freeze_mem_wb`  out  1  hold MEM/WB.
- `flush_if_id`  out  1  load a NOP into IF/ID at the next edge.
- `flush_id_exe`  out  1  load a NOP (all controls 0) into ID/EXE at the next edge.
- `mem_err`  out  1  sticky: a cache wait exceeded `MEM_TIMEOUT`.
- `stall_cnt`  out  `CNT_W`  number of cycles in which `freeze_pc` was asserted.

## Operation
- The FSM has two states, `RUN` and `MEM_WAIT`. Reset forces `RUN`, `wait_cnt`=0, `stall_cnt`=0 and `mem_err`=0.
- The freeze/flush outputs are combinational functions of the state and inputs. While `rst_b` is asserted, all freeze and flush outputs are 0.
- Priority in `RUN`, highest first:
  - **Cache miss**: `mem_cache_en & ~mem_ready`.
    - Assert all five freezes. Both flushes are 0.
    - Next state is `MEM_WAIT`.
  - **Jump**: `exe_jump != 0`.
    - Assert `flush_if_id` and `flush_id_exe`. No freeze.
    - Any load-use hazard this cycle is ignored, because the ID instruction is being discarded.
  - **Load-use**: `exe_mem_to_reg & exe_rd_addr != 0` and either `(id_uses_rs & id_rs_addr == exe_rd_addr)` or `(id_uses_rt & id_rt_addr == exe_rd_addr)`.
    - Assert `freeze_pc`, `freeze_if_id` and `flush_id_exe`.
    - EXE/MEM and MEM/WB advance.
  - **Otherwise**: all outputs 0.
- In `MEM_WAIT`:
  - While `~mem_ready`: all five freezes are asserted, flushes are 0, and `wait_cnt` increments (saturating).
  - When `mem_ready`=1: freezes are released that cycle and the next state is `RUN`.
    - Jump and load-use are evaluated that same cycle with the `RUN` rules, because the frozen EXE/ID contents are still valid.
  - `wait_cnt` clears on every entry into `MEM_WAIT`.
  - When `wait_cnt` reaches `MEM_TIMEOUT-1` while still waiting, `mem_err` sets and stays set until reset. The FSM keeps waiting.
- `mem_ready` is ignored when `mem_cache_en`=0 in `RUN`.
- `stall_cnt` increments on each edge where `freeze_pc`=1 and wraps modulo 2^`CNT_W`.

## Timing
- Zero-latency control: outputs respond in the same cycle as their inputs, with no registered delay.
- The load-use bubble lasts exactly one cycle. At the next edge the load has moved to MEM, so the hazard disappears unless a new load is in EXE.
- A cache hit (`mem_cache_en=1`, `mem_ready=1` in the same cycle) causes no stall and no state change.
- For a miss whose `mem_ready` arrives N cycles after the access starts, the freeze lasts N cycles and `stall_cnt` grows by N.
- Asserting reset mid-wait aborts `MEM_WAIT` immediately: outputs drop to 0 and the state is `RUN` after reset releases.

## Structure
- The shared package `pipe_ctrl_pkg` holds:
  - the `hz_state_t` enum (`RUN`, `MEM_WAIT`);
  - `REG_ZERO` = 5'd0;
  - the `JUMP_NONE` = 2'b00 encoding.
- One sub-module, `load_use_detect`, is purely combinational: register compares producing `hazard`. The FSM and counters stay in the top module.

## Test plan
- Load-use: EXE load to r5, ID `add` with rs=5, `id_uses_rs`=1 -> for one cycle `freeze_pc`=`freeze_if_id`=`flush_id_exe`=1, other freezes 0; all 0 the next cycle; `stall_cnt`=1.
- Load into r0: `exe_rd_addr`=0 and ID reads r0 -> no stall. Load to r5 but ID rt=5 with `id_uses_rt`=0 -> no stall.
- Cache miss:
  - `mem_cache_en`=1 with `mem_ready` low for 3 cycles -> all freezes high for 3 cycles; release in the cycle `mem_ready`=1; `stall_cnt`=3.
  - Hit (`mem_ready`=1 immediately) -> no freeze.
- Jump versus hazard: `exe_jump`=2'b01 together with a load-use condition -> only both flushes are asserted, no freeze. Jump during `MEM_WAIT` -> no flush until the `mem_ready` cycle, then both flushes.
- Timeout: `MEM_TIMEOUT`=4, `mem_ready` held low for 6 cycles -> `mem_err` rises after 4 wait cycles and stays 1 after `mem_ready` and return to `RUN`.
- Reset mid-wait: `rst_b`=1 during the third cycle of `MEM_WAIT` -> all outputs 0 at once, `stall_cnt`=0, `mem_err`=0; after release with `mem_cache_en`=0, the FSM stays in `RUN`.
